// File: rtl/sum_accumulator.sv
// Signed column-sum accumulator: adds acc_len beats into one element,
// optional ReLU on the result, one-deep output register with handshake.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input beat handshake, in_data signed column sum
//   acc_len, relu_en  beats per element (first beat), ReLU (last beat)
//   flush             drops the partial element
//   out_valid/ready   output handshake, out_data signed result
//   busy, elem_cnt    partial element held, elements produced
module sum_accumulator #(
   parameter int bw      = 8,
   parameter int bw_psum = 2*bw+4,
   parameter int in_w    = bw_psum+4,
   parameter int acc_w   = in_w+4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [in_w-1:0]  in_data,
   output logic             in_ready,
   input  logic [4:0]       acc_len,
   input  logic             relu_en,
   input  logic             flush,
   output logic             out_valid,
   output logic [acc_w-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic [15:0]      elem_cnt
);

   typedef enum logic {IDLE, ACC} state_t;

   state_t                  state, state_nx;
   logic [4:0]              len_q;
   logic [4:0]              count;
   logic signed [acc_w-1:0] acc;

   logic [4:0]              eff_len;
   logic [4:0]              cur_len;
   logic [4:0]              next_count;
   logic signed [acc_w-1:0] in_ext;
   logic signed [acc_w-1:0] sum;
   logic                    accept;
   logic                    last;

   assign in_ready = !(out_valid && !out_ready);
   assign accept   = in_valid && in_ready;

   // 0 means a single beat; anything above 16 clamps to 16
   always_comb begin
      eff_len = acc_len;
      if (acc_len == 5'd0)
         eff_len = 5'd1;
      else if (acc_len > 5'd16)
         eff_len = 5'd16;
   end

   assign in_ext     = acc_w'($signed(in_data));
   assign cur_len    = (state == IDLE) ? eff_len : len_q;
   assign next_count = (state == IDLE) ? 5'd1 : count + 5'd1;
   assign sum        = (state == IDLE) ? in_ext : acc + in_ext;
   // a beat landing with flush is dropped, so it can never finish
   assign last       = accept && !flush && (next_count == cur_len);

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush)
         state_nx = IDLE;
      else if (accept)
         state_nx = last ? IDLE : ACC;
   end

   always_comb begin
      busy = (state == ACC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= '0;
         count <= '0;
         len_q <= '0;
      end else if (flush) begin
         acc   <= '0;
         count <= '0;
      end else if (accept) begin
         if (state == IDLE)
            len_q <= eff_len;
         if (last) begin
            acc   <= '0;
            count <= '0;
         end else begin
            acc   <= sum;
            count <= next_count;
         end
      end
   end

   // in_ready blocks new beats while a result is stalled, so a last
   // beat only arrives when the register is empty or being drained
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         elem_cnt  <= '0;
      end else if (last) begin
         out_valid <= 1'b1;
         out_data  <= (relu_en && sum[acc_w-1]) ? '0 : sum;
         elem_cnt  <= elem_cnt + 16'd1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed beats, a list-based reference
// model checked every cycle, plus literal expectations.
module tb_sum_accumulator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [23:0] in_data = '0;
   logic        in_ready;
   logic [4:0]  acc_len = 5'd1;
   logic        relu_en = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic [27:0] out_data;
   logic        out_ready = 1'b1;
   logic        busy;
   logic [15:0] elem_cnt;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   sum_accumulator dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .acc_len   (acc_len),
      .relu_en   (relu_en),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .elem_cnt  (elem_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // reference: element = list of accepted beats, summed when full
   longint beats[$];
   int     m_len = 0;
   bit     m_ov = 1'b0;
   longint m_data = 0;
   int     m_cnt = 0;

   always @(posedge clk) begin
      bit     rdy;
      bit     take;
      longint tot;
      if (reset) begin
         beats.delete();
         m_ov = 1'b0;
         m_data = 0;
         m_cnt = 0;
      end else begin
         rdy = !(m_ov && !out_ready);
         take = in_valid && rdy;
         if (m_ov && out_ready)
            m_ov = 1'b0;
         if (flush) begin
            beats.delete();
         end else if (take) begin
            if (beats.size() == 0) begin
               if (acc_len == 0) m_len = 1;
               else if (acc_len > 16) m_len = 16;
               else m_len = int'(acc_len);
            end
            beats.push_back(longint'($signed(in_data)));
            if (beats.size() == m_len) begin
               tot = 0;
               foreach (beats[i]) tot += beats[i];
               if (relu_en && tot < 0) tot = 0;
               m_ov = 1'b1;
               m_data = tot;
               m_cnt = (m_cnt + 1) & 16'hFFFF;
               beats.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_out_valid", longint'(out_valid), longint'(m_ov));
         chk("m_busy", longint'(busy), longint'(beats.size() != 0));
         chk("m_in_ready", longint'(in_ready), longint'(!(m_ov && !out_ready)));
         chk("m_elem_cnt", longint'(elem_cnt), longint'(m_cnt));
         if (m_ov)
            chk("m_out_data", longint'($signed(out_data)), m_data);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input longint d);
      in_valid = 1'b1;
      in_data = d[23:0];
      cyc();
      in_valid = 1'b0;
   endtask

   initial begin
      cyc();
      chk_en = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_elem_cnt", longint'(elem_cnt), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_in_ready", longint'(in_ready), 1);

      // 5,-2,10 -> 13
      acc_len = 5'd3;
      beat(5);
      chk("busy_mid", longint'(busy), 1);
      acc_len = 5'd1;
      beat(-2);
      beat(10);
      chk("sum3_valid", longint'(out_valid), 1);
      chk("sum3_data", longint'(out_data), 13);
      chk("sum3_cnt", longint'(elem_cnt), 1);
      chk("sum3_busy", longint'(busy), 0);
      cyc();
      chk("sum3_drained", longint'(out_valid), 0);

      // -7,3 -> -4, then ReLU (sampled on last beat) -> 0
      acc_len = 5'd2;
      beat(-7);
      beat(3);
      chk("neg_data", longint'(out_data), 28'hFFFFFFC);
      beat(-7);
      relu_en = 1'b1;
      beat(3);
      relu_en = 1'b0;
      chk("relu_data", longint'(out_data), 0);
      chk("relu_cnt", longint'(elem_cnt), 3);
      cyc();

      // backpressure: 200 waits until 100 is taken
      acc_len = 5'd1;
      out_ready = 1'b0;
      beat(100);
      in_valid = 1'b1;
      in_data = 24'd200;
      chk("bp_ready_lo", longint'(in_ready), 0);
      cyc();
      cyc();
      chk("bp_hold_data", longint'(out_data), 100);
      chk("bp_hold_cnt", longint'(elem_cnt), 4);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_hi", longint'(in_ready), 1);
      cyc();
      in_valid = 1'b0;
      chk("bp_next_valid", longint'(out_valid), 1);
      chk("bp_next_data", longint'(out_data), 200);
      chk("bp_next_cnt", longint'(elem_cnt), 5);
      cyc();
      chk("bp_empty", longint'(out_valid), 0);

      // length boundaries
      acc_len = 5'd0;
      beat(42);
      chk("len0_data", longint'(out_data), 42);
      acc_len = 5'd16;
      for (int i = 0; i < 16; i++) beat(-(64'sd1 <<< 23));
      chk("len16_data", longint'(out_data), 28'h8000000);
      chk("len16_cnt", longint'(elem_cnt), 7);
      acc_len = 5'd31;
      beat(1);
      acc_len = 5'd1;
      for (int i = 0; i < 14; i++) beat(1);
      chk("clamp_busy", longint'(busy), 1);
      beat(1);
      chk("clamp_data", longint'(out_data), 16);
      cyc();

      // flush discards partial and the coincident beat
      acc_len = 5'd4;
      beat(9);
      beat(9);
      flush = 1'b1;
      beat(9);
      flush = 1'b0;
      chk("flush_busy", longint'(busy), 0);
      chk("flush_cnt", longint'(elem_cnt), 8);
      for (int i = 0; i < 4; i++) beat(1);
      chk("flush_data", longint'(out_data), 4);
      chk("flush_after_cnt", longint'(elem_cnt), 9);

      // reset mid-element with a result still held
      out_ready = 1'b0;
      cyc();
      acc_len = 5'd3;
      out_ready = 1'b1;
      beat(7);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("mrst_valid", longint'(out_valid), 0);
      chk("mrst_cnt", longint'(elem_cnt), 0);
      chk("mrst_busy", longint'(busy), 0);
      chk("mrst_ready", longint'(in_ready), 1);
      for (int i = 0; i < 3; i++) beat(1);
      chk("mrst_data", longint'(out_data), 3);
      chk("mrst_cnt1", longint'(elem_cnt), 1);
      cyc();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter bw, default 8: activation/weight bit width.
REQ-002 Parameter bw_psum, default 2*bw+4 (20): per-column partial-sum width.
REQ-003 Parameter in_w, default bw_psum+4 (24): width of the column-sum word from the upstream CSA adder tree.
REQ-004 Parameter acc_w, default in_w+4 (28): accumulator and result width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk  input  1: rising-edge clock.
REQ-007 Port reset  input  1: synchronous, active-high reset.
REQ-008 Port in_valid  input  1: in_data carries a valid signed column sum.
REQ-009 Port in_data  input  in_w: signed two's-complement column sum (adder-tree output S).
REQ-010 Port in_ready  output  1: block accepts in_data this cycle.
REQ-011 Port acc_len  input  5: number of beats per output element, 1..16, sampled on the first beat of each element.
REQ-012 Port relu_en  input  1: apply ReLU to the result, sampled on the last beat.
REQ-013 Port flush  input  1: single-cycle pulse that discards the partial accumulation.
REQ-014 Port out_valid  output  1: out_data holds a finished element.
REQ-015 Port out_data  output  acc_w: signed accumulated result.
REQ-016 Port out_ready  input  1: consumer takes out_data this cycle.
REQ-017 Port busy  output  1: high when a partial accumulation is in progress.
REQ-018 Port elem_cnt  output  16: number of elements produced since reset, wraps 0xFFFF->0x0000.

Function
REQ-019 A beat SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-020 in_ready SHALL be !(out_valid && !out_ready), a combinational function of registered out_valid and out_ready.
REQ-021 The FSM SHALL have two states: IDLE (no beats held) and ACC (1..len-1 beats held); busy = (state==ACC).
REQ-022 In IDLE, an accepted beat SHALL latch len = (acc_len==0 ? 1 : min(acc_len,16)), load acc = sign-extended in_data, and set count = 1.
REQ-023 In ACC, an accepted beat SHALL add sign-extended in_data to acc and increment count.
REQ-024 The beat that makes count equal len SHALL be the last beat; a 1-beat element in IDLE is both first and last.
REQ-025 On the last beat, the FSM SHALL return to IDLE, and on the next edge out_data SHALL be the final sum, or 0 if relu_en is high and the sum is negative; out_valid SHALL be 1 and elem_cnt SHALL increment (latency one cycle).
REQ-026 The acc_w-bit accumulator SHALL be exact for up to 16 beats with no saturation or overflow logic.
REQ-027 out_valid SHALL stay high and out_data SHALL stay stable until out_valid && out_ready; then out_valid clears unless a new last beat is accepted in the same cycle, in which case the new result loads and out_valid stays 1.
REQ-028 A flush SHALL return the FSM to IDLE and clear acc/count; a beat accepted in the same cycle is discarded; the output register and elem_cnt are unaffected.
REQ-029 acc_len and relu_en changes mid-element SHALL not affect the element in progress except as stated in REQ-011/REQ-012.

Reset
REQ-030 On reset the block SHALL set state=IDLE, acc=0, count=0, out_valid=0, out_data=0, elem_cnt=0, busy=0.
REQ-031 When out_valid=0, in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-032 Reset asserted mid-element or with out_valid=1 SHALL discard all data with no output beat.

Verification
REQ-033 acc_len=3, relu_en=0, beats 5,-2,10, out_ready=1 -> one cycle after beat 3: out_valid=1, out_data=13, elem_cnt=1.
REQ-034 acc_len=2, beats -7,3: with relu_en=0 -> out_data=0xFFFFFFC (-4); repeated with relu_en=1 -> out_data=0.
REQ-035 acc_len=1, out_ready=0, beats 100 then 200 -> out_data=100 held, in_ready=0 after the first result, 200 not accepted; out_ready=1 for one cycle -> 100 consumed, 200 accepted that cycle, out_data=200 the next cycle.
REQ-036 acc_len=0 with beat 42 -> treated as len 1, out_data=42; acc_len=16 with 16 beats of -2^23 -> out_data=0x8000000, no wrap.
REQ-037 acc_len=4, two beats of 9, then flush together with a third beat of 9, then 4 beats of 1 -> out_data=4, busy=0 after flush.
REQ-038 acc_len=3, one beat of 7, then reset pulse -> out_valid=0, elem_cnt=0, busy=0; next element 1,1,1 -> out_data=3.
